// File: rtl/mul_nibble_seq_ctrl_if.sv
// Operand/product handshake bundle for the nibble-serial multiplier controller.
interface mul_nibble_seq_ctrl_if #(
  parameter int N = 2
);
  localparam int W = 4 * N;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mul_nibble_seq_ctrl.sv
// Wide unsigned multiplier built by time-sharing one 4x4 multiplier across
// all nibble pairs, accumulating shifted partial products over N*N cycles.
module mul_nibble_seq_ctrl #(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_nibble_seq_ctrl_if.slave  bus
);
  localparam int W  = 4 * N;
  localparam int PW = 8 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p_q, p_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;

  logic [3:0]    mul_x;
  logic [3:0]    mul_y;
  logic [7:0]    pp;
  logic [IW:0]   ij_sum;
  logic [PW-1:0] term;

  assign mul_x  = a_q[{i_q, 2'b00} +: 4];
  assign mul_y  = b_q[{j_q, 2'b00} +: 4];
  assign ij_sum = {1'b0, i_q} + {1'b0, j_q};
  assign term   = PW'(pp) << {ij_sum, 2'b00};

  _4x4_multiplier u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  // in_ready is also gated by rst_n so it stays low for the whole reset window
  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.p         = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = acc_q + term;
        if (i_q == LAST) begin
          i_d = '0;
          // p is loaded on the final step so it is already valid on DONE entry
          if (j_q == LAST) begin
            j_d     = '0;
            p_d     = acc_q + term;
            state_d = DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

module _4x4_multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  assign p = {4'b0000, x} * {4'b0000, y};
endmodule

// File: tb/tb_mul_nibble_seq_ctrl.sv
// Self-checking bench: directed cases on an N=2 instance and a randomized
// sweep on an N=4 instance, both against a plain a*b reference.
module tb_mul_nibble_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  mul_nibble_seq_ctrl_if #(.N(2)) bus2 ();
  mul_nibble_seq_ctrl_if #(.N(4)) bus4 ();

  mul_nibble_seq_ctrl #(.N(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  mul_nibble_seq_ctrl #(.N(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full N=2 transaction with optional consumer stall after out_valid
  task automatic applyStimulus2(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [15:0] exp;
    int waited;
    int accept_cycle;
    exp = 16'(a) * 16'(b);
    @(negedge clk);
    bus2.a = a;
    bus2.b = b;
    bus2.in_valid = 1'b1;
    bus2.out_ready = (stall == 0);
    waited = 0;
    while (!bus2.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("n2_ready_before_accept", 64'(bus2.in_ready), 64'd1);
    if (!bus2.in_ready) begin
      bus2.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    bus2.in_valid = 1'b0;
    bus2.a = 8'($urandom);
    bus2.b = 8'($urandom);
    @(negedge clk);
    checkOutput("n2_ready_low_in_run", 64'(bus2.in_ready), 64'd0);
    checkOutput("n2_busy_in_run", 64'(bus2.busy), 64'd1);
    waited = 0;
    while (!bus2.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("n2_latency", 64'(cycle - accept_cycle), 64'd4);
    checkOutput("n2_product", 64'(bus2.p), 64'(exp));
    for (int k = 0; k < stall; k++) begin
      checkOutput("n2_stall_valid", 64'(bus2.out_valid), 64'd1);
      checkOutput("n2_stall_p", 64'(bus2.p), 64'(exp));
      checkOutput("n2_stall_ready", 64'(bus2.in_ready), 64'd0);
      bus2.in_valid = k[0];
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("n2_post_valid", 64'(bus2.out_valid), 64'd0);
    checkOutput("n2_post_ready", 64'(bus2.in_ready), 64'd1);
    checkOutput("n2_post_busy", 64'(bus2.busy), 64'd0);
    checkOutput("n2_post_p_hold", 64'(bus2.p), 64'(exp));
  endtask

  task automatic applyStimulus4(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] exp;
    int waited;
    int accept_cycle;
    exp = 32'(a) * 32'(b);
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    bus4.in_valid = 1'b1;
    bus4.out_ready = 1'b1;
    waited = 0;
    while (!bus4.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus4.in_ready) begin
      checkOutput("n4_accept_timeout", 64'(bus4.in_ready), 64'd1);
      bus4.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    bus4.in_valid = 1'b0;
    bus4.a = 16'($urandom);
    bus4.b = 16'($urandom);
    waited = 0;
    @(negedge clk);
    while (!bus4.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("n4_run_length", 64'(cycle - accept_cycle), 64'd16);
    checkOutput("n4_product", 64'(bus4.p), 64'(exp));
  endtask

  logic [7:0] b2b_a [3] = '{8'h11, 8'h80, 8'hFF};
  logic [7:0] b2b_b [3] = '{8'h11, 8'h02, 8'h01};

  initial begin
    int acc_cyc [3];
    int waited;
    logic [15:0] ra;
    logic [15:0] rb;

    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = '0; bus2.b = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0;

    #12;
    checkOutput("rst_in_ready", 64'(bus2.in_ready), 64'd0);
    checkOutput("rst_busy", 64'(bus2.busy), 64'd0);
    checkOutput("rst_out_valid", 64'(bus2.out_valid), 64'd0);
    checkOutput("rst_p", 64'(bus2.p), 64'd0);
    checkOutput("rst_n4_in_ready", 64'(bus4.in_ready), 64'd0);
    rst_n = 1'b1;

    applyStimulus2(8'h12, 8'h34, 0);
    applyStimulus2(8'hFF, 8'hFF, 0);
    applyStimulus2(8'h00, 8'hA7, 0);
    applyStimulus2(8'h0F, 8'h10, 10);

    // Abort in the middle of RUN
    @(negedge clk);
    bus2.a = 8'hAB; bus2.b = 8'hCD; bus2.in_valid = 1'b1; bus2.out_ready = 1'b1;
    checkOutput("abort_ready", 64'(bus2.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(bus2.out_valid), 64'd0);
    checkOutput("abort_busy", 64'(bus2.busy), 64'd0);
    checkOutput("abort_p", 64'(bus2.p), 64'd0);
    checkOutput("abort_in_ready", 64'(bus2.in_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 64'(bus2.out_valid), 64'd0);
    end
    applyStimulus2(8'h03, 8'h05, 0);

    // Back-to-back with in_valid held high
    @(negedge clk);
    bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      bus2.a = b2b_a[t];
      bus2.b = b2b_b[t];
      waited = 0;
      while (!bus2.in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      @(posedge clk);
      #1;
      acc_cyc[t] = cycle;
      waited = 0;
      @(negedge clk);
      while (!bus2.out_valid && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("b2b_product", 64'(bus2.p), 64'(16'(b2b_a[t]) * 16'(b2b_b[t])));
      if (t > 0) checkOutput("b2b_interval", 64'(acc_cyc[t] - acc_cyc[t-1]), 64'd6);
    end
    bus2.in_valid = 1'b0;

    for (int k = 0; k < 20; k++) begin
      applyStimulus2(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    applyStimulus4(16'hFFFF, 16'hFFFF);
    applyStimulus4(16'h0000, 16'hFFFF);
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus4(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
